// File: rtl/blackjack_dealer_arb.sv
`timescale 1ns/1ps
// blackjack_dealer_arb: round-robin dealer sharing one deck among N player units.
// A grant pops one legal card from the deck and offers it to the winner on a held
// card_rdy. The dealer then waits for that player to drop its request (or finish)
// before it arbitrates again.
//
// Handshakes:
//   deck side   - deck_valid says deck_value is meaningful. deck_pop is a
//                 combinational strobe, high only in FETCH and only while
//                 deck_valid is high. A card is consumed on any clock edge where
//                 deck_pop=1. Illegal values (0, 11..15) are consumed and dropped.
//   player side - card_rdy[i] is high for HOLD_CYCLES cycles. card_value is valid
//                 whenever any card_rdy bit is high. The player acknowledges by
//                 lowering player_req[i] or raising player_done[i].
module blackjack_dealer_arb #(
  parameter  int N_PLAYERS   = 4,
  parameter  int HOLD_CYCLES = 2,
  parameter  int CNT_W       = 8,
  localparam int ID_W        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_PLAYERS-1:0] player_req,
  input  logic [N_PLAYERS-1:0] player_done,
  input  logic                 deck_valid,
  input  logic [3:0]           deck_value,
  output logic                 deck_pop,
  output logic [N_PLAYERS-1:0] card_rdy,
  output logic [3:0]           card_value,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 round_over,
  output logic [CNT_W-1:0]     cards_dealt,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DEAL    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [3:0]             card_q, card_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   round_over_q;

  logic [N_PLAYERS-1:0]   elig;
  logic                   pick_found;
  logic [ID_W-1:0]        pick_idx;
  logic [ID_W:0]          scan_idx;
  logic                   card_legal;

  assign elig       = player_req & ~player_done;
  assign card_legal = (deck_value >= 4'd1) && (deck_value <= 4'd10);

  // Round-robin pick: first eligible player at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (scan_idx >= (ID_W+1)'(N_PLAYERS)) begin
        scan_idx = scan_idx - (ID_W+1)'(N_PLAYERS);
      end
      if (!pick_found && elig[scan_idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // Next-state logic for the deal sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    card_d  = card_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (&player_done) begin
          state_d = S_DONE;
        end else if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Illegal cards are popped and dropped; keep fetching until a legal one.
        if (deck_valid && card_legal) begin
          card_d  = deck_value;
          hold_d  = '0;
          state_d = S_DEAL;
        end
      end
      S_DEAL: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          ptr_d   = (grant_q == ID_W'(N_PLAYERS - 1)) ? '0 : grant_q + ID_W'(1);
          state_d = S_RELEASE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RELEASE: begin
        // Hold off re-arbitration until the served player lets go of its request.
        if (!player_req[grant_q] || player_done[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      card_q       <= '0;
      hold_q       <= '0;
      cnt_q        <= '0;
      round_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      card_q       <= card_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      round_over_q <= &player_done;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    card_rdy = '0;
    if (state_q == S_DEAL) begin
      card_rdy[grant_q] = 1'b1;
    end
    deck_pop   = (state_q == S_FETCH) && deck_valid;
    busy       = (state_q == S_FETCH) || (state_q == S_DEAL) || (state_q == S_RELEASE);
    round_over = (state_q == S_DONE) || ((state_q == S_IDLE) && round_over_q);
  end

  assign card_value  = card_q;
  assign grant_id    = grant_q;
  assign cards_dealt = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_blackjack_dealer_arb.sv
`timescale 1ns/1ps
// tb_blackjack_dealer_arb: randomized deals against a transaction-level dealer
// model. The driver pushes the expected {player, card} for each deal into
// exp_q, and the monitor pops one entry on each card_rdy pulse.
module tb_blackjack_dealer_arb;
  localparam int N      = 4;
  localparam int HOLD   = 2;
  localparam int CNT_W  = 4;
  localparam int EXP_W  = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     player_req, player_done;
  logic             deck_valid;
  logic [3:0]       deck_value;
  logic             deck_pop;
  logic [N-1:0]     card_rdy;
  logic [3:0]       card_value;
  logic [1:0]       grant_id;
  logic             busy, round_over;
  logic [CNT_W-1:0] cards_dealt;
  logic [2:0]       dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [3:0]       deck_q[$];
  int               stall_cnt   = 0;
  bit               valid_always = 1'b1;
  int               ptr_m       = 0;

  blackjack_dealer_arb #(.N_PLAYERS(N), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .player_req(player_req), .player_done(player_done),
    .deck_valid(deck_valid), .deck_value(deck_value), .deck_pop(deck_pop),
    .card_rdy(card_rdy), .card_value(card_value), .grant_id(grant_id), .busy(busy),
    .round_over(round_over), .cards_dealt(cards_dealt), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first eligible player at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] rand_junk();
    int r;
    r = $urandom_range(0, 5);
    return (r == 0) ? 4'd0 : 4'(10 + r);
  endfunction

  // Deck model: presents its queue head, consumes it on deck_pop.
  initial begin
    deck_valid = 1'b0;
    deck_value = 4'd0;
    forever begin
      @(negedge clock);
      if (stall_cnt > 0) begin
        stall_cnt--;
        deck_valid = 1'b0;
        deck_value = 4'($urandom_range(0, 15));
      end else if (deck_q.size() > 0 && (valid_always || $urandom_range(0, 3) != 0)) begin
        deck_valid = 1'b1;
        deck_value = deck_q[0];
      end else begin
        deck_valid = 1'b0;
        deck_value = 4'($urandom_range(0, 15));
      end
      #2;
      if (deck_pop && !deck_valid) check("pop_without_valid", 1, 0);
      if (deck_pop && deck_valid && deck_q.size() > 0) void'(deck_q.pop_front());
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit               in_deal = 1'b0;
    int               hl = 0;
    int               exp_dealt = 0;
    logic [EXP_W-1:0] e;
    logic [N-1:0]     oh;
    logic [N-1:0]     first_rdy;
    logic [3:0]       first_val;
    forever begin
      @(negedge clock);
      if (reset) begin
        in_deal   = 1'b0;
        exp_dealt = 0;
      end else if (card_rdy != '0 && !in_deal) begin
        in_deal   = 1'b1;
        hl        = 1;
        first_rdy = card_rdy;
        first_val = card_value;
        if (exp_q.size() == 0) begin
          check("unexpected_deal", {card_rdy, card_value}, 0);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e[5:4];
          check("deal_start", {card_rdy, card_value, grant_id, busy, round_over},
                {oh, e[3:0], e[5:4], 1'b1, 1'b0});
        end
      end else if (card_rdy != '0 && in_deal) begin
        hl++;
        check("deal_stable", {card_rdy, card_value}, {first_rdy, first_val});
      end else if (card_rdy == '0 && in_deal) begin
        in_deal = 1'b0;
        check("hold_len", hl, HOLD);
        if (exp_dealt < (1 << CNT_W) - 1) exp_dealt++;
        check("cards_dealt", cards_dealt, exp_dealt);
      end
    end
  end

  task automatic apply_reset();
    reset       = 1'b1;
    player_req  = '0;
    player_done = '0;
    deck_q.delete();
    stall_cnt   = 0;
    @(negedge clock); #1;
    @(negedge clock); #1;
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // One full deal transaction; called at negedge+1.
  task automatic do_txn(input logic [N-1:0] req, input logic [N-1:0] done, input logic [3:0] val_in,
                        input int n_junk, input int stall, input int extra_hold,
                        input bit drop_by_done, output int lat);
    int         g;
    logic [3:0] v;
    bit         got;
    g = pick(req & ~done, ptr_m);
    v = (val_in == 4'd0) ? 4'($urandom_range(1, 10)) : val_in;
    exp_q.push_back({2'(g), v});
    for (int k = 0; k < n_junk; k++) deck_q.push_back(rand_junk());
    deck_q.push_back(v);
    stall_cnt   = stall;
    player_done = done;
    player_req  = req;
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clock); #1;
      lat++;
      if (card_rdy != '0) got = 1'b1;
    end
    check("deal_start_timeout", got, 1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock); #1;
      if (card_rdy == '0) got = 1'b1;
    end
    check("deal_end_timeout", got, 1);
    for (int k = 0; k < extra_hold; k++) begin
      check("release_hold", {busy, card_rdy}, 5'b10000);
      @(negedge clock); #1;
    end
    if (drop_by_done && ((done | (4'b0001 << g)) != 4'b1111)) begin
      player_done = done | (4'b0001 << g);
      player_req  = 4'b0001 << g;
    end else begin
      player_req = '0;
    end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock); #1;
      if (!busy) got = 1'b1;
    end
    check("release_exit", got, 1);
    ptr_m = (g + 1) % N;
  endtask

  // Stimulus.
  initial begin
    int         lat;
    logic [N-1:0] rq, dn;
    bit         got;
    reset = 1'b1;
    player_req = '0;
    player_done = '0;
    apply_reset();
    check("reset_state", {card_rdy, deck_pop, busy, round_over, cards_dealt, card_value, grant_id, dbg_state},
          '0);

    // Single request, always-valid deck: fixed latency.
    do_txn(4'b0001, 4'b0000, 4'd3, 0, 0, 0, 1'b0, lat);
    check("t1_latency", lat, 2);

    // All players requesting: strict rotation including the wrap.
    for (int i = 0; i < 5; i++) do_txn(4'b1111, 4'b0000, 4'd0, 0, 0, $urandom_range(0, 2), 1'b0, lat);

    // Two illegal cards ahead of a legal one.
    do_txn(4'b0100, 4'b0000, 4'd7, 2, 0, 0, 1'b0, lat);
    check("t3_latency", lat, 4);

    // Deck stalled for 10 cycles after the grant.
    do_txn(4'b1000, 4'b0000, 4'd5, 0, 10, 0, 1'b0, lat);
    check("t4_latency", lat, 12);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      valid_always = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) begin
        rq = 4'b1111;
        dn = 4'b0000;
      end else begin
        do begin
          rq = 4'($urandom_range(1, 15));
          dn = 4'($urandom_range(0, 14));
        end while ((rq & ~dn) == '0);
      end
      do_txn(rq, dn, 4'd0, $urandom_range(0, 2), 0, $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), lat);
    end
    valid_always = 1'b1;

    // Finished player never granted, then everyone done.
    do_txn(4'b0011, 4'b0010, 4'd0, 0, 0, 0, 1'b0, lat);
    player_done = 4'b1111;
    player_req  = 4'b1111;
    deck_q.push_back(4'd6);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); #1;
      check("done_state", {round_over, busy, card_rdy, deck_pop}, 7'b1000000);
    end
    check("done_no_pop", deck_q.size(), 1);
    apply_reset();

    // Reset on the first deal cycle.
    exp_q.push_back({2'd0, 4'd9});
    deck_q.push_back(4'd9);
    player_req = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clock); #1;
      if (card_rdy != '0) got = 1'b1;
    end
    check("t6_deal_seen", got, 1);
    reset      = 1'b1;
    player_req = '0;
    @(negedge clock); #1;
    check("t6_after_reset", {card_rdy, cards_dealt, busy, grant_id, dbg_state}, '0);
    reset = 1'b0;
    ptr_m = 0;
    do_txn(4'b1111, 4'b0000, 4'd0, 0, 0, 0, 1'b0, lat);
    check("t6_ptr_zero_grant", grant_id, 0);

    repeat (3) @(negedge clock);
    check("exp_q_drained", exp_q.size(), 0);
    check("deck_drained", deck_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
